dds_sweep_ctrl: RTL

- Frequency-sweep scheduler for the DDS/DAC904 sine path.
- Generates the `phase_en` / `set_phase_step` update stream that drives the DDS top level. It steps the phase-step word from a start value toward a stop value, holding each point for a programmable dwell, in single, sawtooth or triangle mode.
- Lives in the `sys_clk` (50 MHz) domain, upstream of the DDS core.

---
 rtl/dds_pkg.sv | 31 +++
 rtl/dds_dwell_timer.sv | 34 +++
 rtl/dds_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: step-word limits shared with the DDS top, plus the sweep scheduler enums.
package dds_pkg;

   localparam logic [31:0] MIN_STEP  = 32'd26;
   localparam logic [31:0] MAX_STEP  = 32'd1301505241;
   localparam logic [31:0] IDLE_STEP = 32'd26030;

   typedef enum logic [1:0] {
      SINGLE = 2'b00,
      SAW    = 2'b01,
      TRI    = 2'b10
   } sweep_mode_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      DWELL  = 3'd2,
      STEP   = 3'd3,
      FINISH = 3'd4
   } sweep_state_t;

   // The reserved encoding 2'b11 behaves as a single sweep.
   function automatic sweep_mode_t decode_mode(input logic [1:0] raw);
      case (raw)
         2'b01:   return SAW;
         2'b10:   return TRI;
         default: return SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: loadable down-counter; expire marks terminal count zero.
module dds_dwell_timer #(
   parameter int unsigned DWELL_W = 24
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   input  logic               run,
   output logic               expire
);

   logic [DWELL_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (run && (count_q != '0)) begin
         count_d = count_q - DWELL_W'(1);
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: phase-step sweep scheduler feeding phase_en/set_phase_step to the DDS core.
// Define DDS_SWEEP_MARKER_EN to add the sweep_marker leg-start strobe output.
//
// state  | meaning
// IDLE   | waiting for start; cfg_* captured into shadow registers on accept
// LOAD   | emit clamped start point, reset leg target/direction, arm dwell
// DWELL  | hold current point until the dwell timer reaches zero
// STEP   | advance toward leg target, reverse (triangle) or end (single)
// FINISH | one-cycle done pulse, then back to IDLE
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int unsigned       STEP_W    = 32,
   parameter int unsigned       DWELL_W   = 24,
   parameter logic [STEP_W-1:0] MIN_STEP  = STEP_W'(dds_pkg::MIN_STEP),
   parameter logic [STEP_W-1:0] MAX_STEP  = STEP_W'(dds_pkg::MAX_STEP),
   parameter logic [STEP_W-1:0] IDLE_STEP = STEP_W'(dds_pkg::IDLE_STEP)
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic [STEP_W-1:0]  cfg_start_step,
   input  logic [STEP_W-1:0]  cfg_stop_step,
   input  logic [STEP_W-1:0]  cfg_incr,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               phase_en,
   output logic [STEP_W-1:0]  set_phase_step,
   output logic               sweep_dir
`ifdef DDS_SWEEP_MARKER_EN
   ,
   output logic               sweep_marker
`endif
);

   sweep_state_t       state_q, state_d;
   sweep_mode_t        mode_q, mode_d;
   logic [STEP_W-1:0]  start_q, start_d;
   logic [STEP_W-1:0]  stop_q, stop_d;
   logic [STEP_W-1:0]  incr_q, incr_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [STEP_W-1:0]  tgt_q, tgt_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic               dir_q, dir_d;
   logic               phase_en_q, phase_en_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               marker_q, marker_d;

   logic               tmr_load;
   logic               tmr_expire;
   logic [DWELL_W-1:0] tmr_val;
   logic [STEP_W-1:0]  cap_start, cap_stop, rev_tgt;
   logic               at_tgt;

   function automatic logic [STEP_W-1:0] clamp_step(input logic [STEP_W-1:0] v);
      if (v < MIN_STEP) return MIN_STEP;
      if (v > MAX_STEP) return MAX_STEP;
      return v;
   endfunction

   // One extra bit catches carry/borrow so the result saturates instead of wrapping.
   function automatic logic [STEP_W-1:0] step_toward(
      input logic [STEP_W-1:0] cur,
      input logic [STEP_W-1:0] incr,
      input logic [STEP_W-1:0] tgt,
      input logic              up
   );
      logic [STEP_W:0] sum;
      logic [STEP_W:0] diff;
      sum  = {1'b0, cur} + {1'b0, incr};
      diff = {1'b0, cur} - {1'b0, incr};
      if (up) begin
         return (sum >= {1'b0, tgt}) ? tgt : sum[STEP_W-1:0];
      end
      return (diff[STEP_W] || (diff[STEP_W-1:0] <= tgt)) ? tgt : diff[STEP_W-1:0];
   endfunction

   dds_dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .run      (state_q == DWELL),
      .expire   (tmr_expire)
   );

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      start_d    = start_q;
      stop_d     = stop_q;
      incr_d     = incr_q;
      dwell_d    = dwell_q;
      tgt_d      = tgt_q;
      step_d     = step_q;
      dir_d      = dir_q;
      phase_en_d = 1'b0;
      done_d     = 1'b0;
      marker_d   = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = dwell_q - DWELL_W'(1);
      cap_start  = clamp_step(cfg_start_step);
      cap_stop   = clamp_step(cfg_stop_step);
      rev_tgt    = (tgt_q == stop_q) ? start_q : stop_q;
      at_tgt     = (step_q == tgt_q);

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               start_d = cap_start;
               stop_d  = cap_stop;
               incr_d  = (cfg_incr == '0) ? STEP_W'(1) : cfg_incr;
               dwell_d = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
               mode_d  = decode_mode(cfg_mode);
               tgt_d   = cap_stop;
               dir_d   = (cap_start <= cap_stop);
               state_d = LOAD;
            end
         end
         LOAD: begin
            step_d     = start_q;
            tgt_d      = stop_q;
            dir_d      = (start_q <= stop_q);
            phase_en_d = 1'b1;
            marker_d   = 1'b1;
            tmr_load   = 1'b1;
            state_d    = DWELL;
         end
         DWELL: begin
            // Sawtooth restart goes straight to LOAD so the strobe spacing stays uniform.
            if (tmr_expire) begin
               state_d = (at_tgt && (mode_q == SAW)) ? LOAD : STEP;
            end
         end
         STEP: begin
            if (!at_tgt) begin
               step_d     = step_toward(step_q, incr_q, tgt_q, dir_q);
               phase_en_d = 1'b1;
               tmr_load   = 1'b1;
               state_d    = DWELL;
            end else if (mode_q == TRI) begin
               tgt_d      = rev_tgt;
               dir_d      = !dir_q;
               step_d     = step_toward(step_q, incr_q, rev_tgt, !dir_q);
               phase_en_d = 1'b1;
               marker_d   = 1'b1;
               tmr_load   = 1'b1;
               state_d    = DWELL;
            end else if (mode_q == SAW) begin
               state_d = LOAD;
            end else begin
               done_d  = 1'b1;
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d    = IDLE;
         step_d     = step_q;
         tgt_d      = tgt_q;
         dir_d      = dir_q;
         phase_en_d = 1'b0;
         done_d     = 1'b0;
         marker_d   = 1'b0;
         tmr_load   = 1'b0;
      end

      busy_d = (state_d == LOAD) || (state_d == DWELL) || (state_d == STEP);
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         mode_q     <= SINGLE;
         start_q    <= IDLE_STEP;
         stop_q     <= IDLE_STEP;
         incr_q     <= STEP_W'(1);
         dwell_q    <= DWELL_W'(1);
         tgt_q      <= IDLE_STEP;
         step_q     <= IDLE_STEP;
         dir_q      <= 1'b1;
         phase_en_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         marker_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         incr_q     <= incr_d;
         dwell_q    <= dwell_d;
         tgt_q      <= tgt_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         phase_en_q <= phase_en_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         marker_q   <= marker_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign phase_en       = phase_en_q;
   assign set_phase_step = step_q;
   assign sweep_dir      = dir_q;

`ifdef DDS_SWEEP_MARKER_EN
   assign sweep_marker = marker_q;
`else
   logic unused_marker;
   assign unused_marker = marker_q;
`endif

endmodule
